// File: rtl/famiclone_probe_pkg.sv
// Shared types for the famiclone power-on probe: FSM states and force_mode encodings.
package famiclone_probe_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        SETTLE = 2'd1,
        PROBE  = 2'd2,
        DONE   = 2'd3
    } probe_state_t;

    localparam logic [1:0] FORCE_STD   = 2'b01;
    localparam logic [1:0] FORCE_CLONE = 2'b10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/famiclone_probe_sync.sv
// Plain flop chain bringing an asynchronous PPU pin into the m2 domain.
module sync_chain #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic m2,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge m2 or posedge reset) begin
        if (reset) ff <= {STAGES{RST_VAL}};
        else       ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/famiclone_probe.sv
// Startup probe: holds the CIRAM grounding window, then votes on /A13 behaviour
// to decide between a standard console and a famiclone driving /A13 itself.
//
// state  | meaning
// HOLD   | grounding window active, timer counts INIT_CYCLES
// SETTLE | window released, samples ignored for SETTLE_CYCLES
// PROBE  | counting A13 level samples and /A13 mismatches, timeout running
// DONE   | verdict frozen until reset
module famiclone_probe
    import famiclone_probe_pkg::*;
#(
    parameter int INIT_CYCLES        = 15,
    parameter int SETTLE_CYCLES      = 4,
    parameter int SAMPLES_PER_LEVEL  = 3,
    parameter int MISMATCH_THRESHOLD = 1,
    parameter int PROBE_TIMEOUT      = 65535,
    parameter int SYNC_STAGES        = 2
) (
    input  logic       m2,
    input  logic       reset,
    input  logic       ppu_rd_in,
    input  logic       ppu_a13,
    input  logic       ppu_not_a13,
    input  logic [1:0] force_mode,
    output logic       ground_out,
    output logic       init_finished,
    output logic       new_dendy,
    output logic       verdict_valid,
    output logic       timed_out
);

    localparam int LW = $clog2(SAMPLES_PER_LEVEL + 1);
    localparam int MW = $clog2(MISMATCH_THRESHOLD + 1);
    localparam int TW = $clog2(max3(INIT_CYCLES, SETTLE_CYCLES, PROBE_TIMEOUT) + 1);

    localparam logic [LW-1:0] LVL_MAX     = LW'(SAMPLES_PER_LEVEL);
    localparam logic [MW-1:0] MM_MAX      = MW'(MISMATCH_THRESHOLD);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(INIT_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(PROBE_TIMEOUT - 1);

    probe_state_t  state, state_nxt;
    logic          rd_s, a13_s, na13_s, rd_prev;
    logic          sample_evt, counted, mismatch, levels_full, tmo_hit, verdict_nxt;
    logic          raw_verdict, timed_out_r;
    logic [TW-1:0] tmr;
    logic [LW-1:0] lo_cnt, hi_cnt, lo_nxt, hi_nxt;
    logic [MW-1:0] mm_cnt, mm_nxt;

    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rd (
        .m2(m2), .reset(reset), .d(ppu_rd_in), .q(rd_s)
    );
    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_a13 (
        .m2(m2), .reset(reset), .d(ppu_a13), .q(a13_s)
    );
    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_na13 (
        .m2(m2), .reset(reset), .d(ppu_not_a13), .q(na13_s)
    );

    assign sample_evt = rd_prev & ~rd_s;
    assign mismatch   = (a13_s == na13_s);

    // A sample only counts while its own level still needs samples.
    always_comb begin
        counted     = sample_evt && (a13_s ? (hi_cnt != LVL_MAX) : (lo_cnt != LVL_MAX));
        lo_nxt      = (counted && !a13_s) ? lo_cnt + 1'b1 : lo_cnt;
        hi_nxt      = (counted &&  a13_s) ? hi_cnt + 1'b1 : hi_cnt;
        mm_nxt      = (counted && mismatch && mm_cnt != MM_MAX) ? mm_cnt + 1'b1 : mm_cnt;
        levels_full = (lo_nxt == LVL_MAX) && (hi_nxt == LVL_MAX);
        tmo_hit     = (tmr == TMO_LAST);
        verdict_nxt = (mm_nxt == MM_MAX);
    end

    always_ff @(posedge m2 or posedge reset) begin
        if (reset) state <= HOLD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HOLD:    if (tmr == HOLD_LAST)       state_nxt = SETTLE;
            SETTLE:  if (tmr == SETTLE_LAST)     state_nxt = PROBE;
            PROBE:   if (levels_full || tmo_hit) state_nxt = DONE;
            default: state_nxt = DONE;
        endcase
    end

    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            rd_prev     <= 1'b1;
            tmr         <= '0;
            lo_cnt      <= '0;
            hi_cnt      <= '0;
            mm_cnt      <= '0;
            raw_verdict <= 1'b0;
            timed_out_r <= 1'b0;
        end else begin
            rd_prev <= rd_s;
            if (state_nxt != state)  tmr <= '0;
            else if (state != DONE)  tmr <= tmr + 1'b1;
            if (state == PROBE) begin
                lo_cnt <= lo_nxt;
                hi_cnt <= hi_nxt;
                mm_cnt <= mm_nxt;
                // A final sample landing on the expiry cycle takes precedence.
                if (state_nxt == DONE) begin
                    raw_verdict <= verdict_nxt;
                    timed_out_r <= !levels_full;
                end
            end
        end
    end

    always_comb begin
        ground_out    = (state == HOLD);
        init_finished = (state != HOLD);
        verdict_valid = (state == DONE);
        timed_out     = timed_out_r;
        case (force_mode)
            FORCE_STD:   new_dendy = 1'b0;
            FORCE_CLONE: new_dendy = 1'b1;
            default:     new_dendy = raw_verdict;
        endcase
    end

endmodule

// File: tb/tb_famiclone_probe.sv
// Scoreboard bench: two probe instances (defaults, and threshold 2 / timeout 100) share stimulus.
module tb_famiclone_probe;

    logic       m2 = 1'b0;
    logic       reset = 1'b1;
    logic       ppu_rd_in = 1'b1;
    logic       ppu_a13 = 1'b0;
    logic       ppu_not_a13 = 1'b1;
    logic [1:0] force_mode = 2'b00;

    logic go_d, if_d, nd_d, vv_d, to_d;
    logic go_t, if_t, nd_t, vv_t, to_t;

    typedef struct {
        logic nd;
        logic to;
        int   cyc;
    } exp_t;

    exp_t q_d[$];
    exp_t q_t[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   t0 = 0;
    logic vvq_d = 1'b0;
    logic vvq_t = 1'b0;

    famiclone_probe u_def (
        .m2(m2), .reset(reset), .ppu_rd_in(ppu_rd_in), .ppu_a13(ppu_a13),
        .ppu_not_a13(ppu_not_a13), .force_mode(force_mode),
        .ground_out(go_d), .init_finished(if_d), .new_dendy(nd_d),
        .verdict_valid(vv_d), .timed_out(to_d)
    );

    famiclone_probe #(.MISMATCH_THRESHOLD(2), .PROBE_TIMEOUT(100)) u_th2 (
        .m2(m2), .reset(reset), .ppu_rd_in(ppu_rd_in), .ppu_a13(ppu_a13),
        .ppu_not_a13(ppu_not_a13), .force_mode(force_mode),
        .ground_out(go_t), .init_finished(if_t), .new_dendy(nd_t),
        .verdict_valid(vv_t), .timed_out(to_t)
    );

    always #5 m2 = ~m2;
    always @(posedge m2) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic got, input logic want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0b want %0b (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic chki(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic mon_pop(input int d, input logic nd, input logic to);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q_d.size() : q_t.size();
        if (sz == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_verdict dut%0d: got verdict_valid=1 want none (cycle %0d)", d, cyc);
        end else begin
            if (d == 0) e = q_d.pop_front();
            else        e = q_t.pop_front();
            chk1($sformatf("dut%0d_new_dendy", d), nd, e.nd);
            chk1($sformatf("dut%0d_timed_out", d), to, e.to);
            chki($sformatf("dut%0d_verdict_cycle", d), cyc, e.cyc);
        end
    endtask

    always @(negedge m2) begin
        if (vv_d && !vvq_d) mon_pop(0, nd_d, to_d);
        if (vv_t && !vvq_t) mon_pop(1, nd_t, to_t);
        vvq_d = vv_d;
        vvq_t = vv_t;
    end

    task automatic do_reset();
        @(negedge m2);
        reset = 1'b1;
        ppu_rd_in = 1'b1;
        ppu_a13 = 1'b0;
        ppu_not_a13 = 1'b1;
        @(negedge m2);
        @(negedge m2);
        reset = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge m2);
    endtask

    // One PPU read: /RD low for one m2 period, then high for one.
    task automatic rd(input logic a, input logic na);
        ppu_a13 = a;
        ppu_not_a13 = na;
        ppu_rd_in = 1'b0;
        @(negedge m2);
        ppu_rd_in = 1'b1;
        @(negedge m2);
    endtask

    task automatic drain();
        repeat (4) @(negedge m2);
        chki("dut0_pending", q_d.size(), 0);
        chki("dut1_pending", q_t.size(), 0);
        q_d.delete();
        q_t.delete();
    endtask

    // Reads listed left-to-right as {a13, not_a13} pairs; verdict due 2 edges after the last read's first edge.
    task automatic scenario(input int n, input logic [15:0] v, input logic e_d, input logic e_t);
        do_reset();
        wait_until(t0 + 20);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                q_d.push_back('{e_d, 1'b0, cyc + 3});
                q_t.push_back('{e_t, 1'b0, cyc + 3});
            end
            rd(v[2*(n-1-i)+1], v[2*(n-1-i)]);
        end
        drain();
    endtask

    initial begin
        #1;
        chk1("rst_ground_d", go_d, 1'b1);
        chk1("rst_ground_t", go_t, 1'b1);
        chk1("rst_init_d", if_d, 1'b0);
        chk1("rst_valid_d", vv_d, 1'b0);
        chk1("rst_dendy_d", nd_d, 1'b0);
        chk1("rst_timeout_d", to_d, 1'b0);
        chk1("rst_valid_t", vv_t, 1'b0);

        @(negedge m2);
        @(negedge m2);
        reset = 1'b0;
        t0 = cyc;
        wait_until(t0 + 14);
        chk1("hold14_ground_d", go_d, 1'b1);
        chk1("hold14_init_d", if_d, 1'b0);
        chk1("hold14_ground_t", go_t, 1'b1);
        @(negedge m2);
        chk1("hold15_ground_d", go_d, 1'b0);
        chk1("hold15_init_d", if_d, 1'b1);
        chk1("hold15_ground_t", go_t, 1'b0);
        chk1("hold15_init_t", if_t, 1'b1);

        scenario(6, {2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10}, 1'b0, 1'b0);
        force_mode = 2'b10;
        #1;
        chk1("force_clone_d", nd_d, 1'b1);
        chk1("force_clone_t", nd_t, 1'b1);
        chk1("force_clone_valid_d", vv_d, 1'b1);
        force_mode = 2'b00;
        #1;
        chk1("force_auto_d", nd_d, 1'b0);

        scenario(6, {2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10}, 1'b1, 1'b1);
        force_mode = 2'b01;
        #1;
        chk1("force_std_d", nd_d, 1'b0);
        chk1("force_std_t", nd_t, 1'b0);
        chk1("force_std_valid_t", vv_t, 1'b1);
        force_mode = 2'b11;
        #1;
        chk1("force_11_t", nd_t, 1'b1);
        force_mode = 2'b00;

        scenario(6, {2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10}, 1'b1, 1'b0);
        scenario(7, {2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10}, 1'b0, 1'b0);

        do_reset();
        q_t.push_back('{1'b0, 1'b1, t0 + 119});
        wait_until(t0 + 125);
        chk1("timeout_nodone_d", vv_d, 1'b0);
        drain();

        do_reset();
        wait_until(t0 + 20);
        rd(1'b0, 1'b0);
        rd(1'b0, 1'b0);
        q_t.push_back('{1'b1, 1'b1, t0 + 119});
        wait_until(t0 + 125);
        drain();

        do_reset();
        wait_until(t0 + 20);
        rd(1'b0, 1'b1);
        rd(1'b1, 1'b0);
        @(negedge m2);
        reset = 1'b1;
        #1;
        chk1("midrst_ground_d", go_d, 1'b1);
        chk1("midrst_ground_t", go_t, 1'b1);
        chki("midrst_lo_d", int'(u_def.lo_cnt), 0);
        chki("midrst_hi_d", int'(u_def.hi_cnt), 0);
        chki("midrst_lo_t", int'(u_th2.lo_cnt), 0);
        @(negedge m2);
        @(negedge m2);
        reset = 1'b0;
        t0 = cyc;
        wait_until(t0 + 20);
        rd(1'b0, 1'b1);
        rd(1'b1, 1'b0);
        rd(1'b0, 1'b1);
        rd(1'b1, 1'b0);
        rd(1'b0, 1'b1);
        @(negedge m2);
        chk1("midrst_5reads_valid_d", vv_d, 1'b0);
        chk1("midrst_5reads_valid_t", vv_t, 1'b0);
        q_d.push_back('{1'b0, 1'b0, cyc + 3});
        q_t.push_back('{1'b0, 1'b0, cyc + 3});
        rd(1'b1, 1'b0);
        drain();

        do_reset();
        force_mode = 2'b10;
        #1;
        chk1("predone_force_dendy_d", nd_d, 1'b1);
        chk1("predone_force_valid_d", vv_d, 1'b0);
        force_mode = 2'b11;
        #1;
        chk1("predone_auto_dendy_d", nd_d, 1'b0);
        force_mode = 2'b00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
